// File: rtl/midi_uart_rx_if.sv
// Byte-level handshake from the MIDI UART receiver to the message capture logic.
interface midi_uart_rx_if;
  logic       new_byte_ready;
  logic [7:0] new_byte;
  logic       framing_error;
  logic       busy;

  modport master (
    output new_byte_ready,
    output new_byte,
    output framing_error,
    output busy
  );

  modport slave (
    input new_byte_ready,
    input new_byte,
    input framing_error,
    input busy
  );
endinterface

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver: synchronises the opto-isolated line, recovers bytes
// LSB-first, rejects start-bit glitches and framing errors, optionally drops
// real-time bytes (F8..FF).
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sample 8 data bits at mid-bit, LSB first
// STOP  | sample the stop bit; emit the byte or flag a framing error
// BREAK | line held low after a bad stop bit; wait for it to go high
module midi_uart_rx #(
  parameter int CLKS_PER_BIT    = 3200,
  parameter bit FILTER_REALTIME = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           midi_in,
  midi_uart_rx_if.master rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_prev;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    new_byte_q;
  logic          new_byte_ready_q;
  logic          framing_error_q;
  logic          tc;
  logic          start_edge;

  // START waits half a bit to land mid start bit; every other wait is a full bit.
  assign tc         = (state == START) ? (baud_cnt == HALF_TC) : (baud_cnt == FULL_TC);
  assign start_edge = rx_s_prev & ~rx_s;

  // Two-flop synchroniser plus the edge-detect history register; idle level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_prev <= 1'b1;
    end else begin
      rx_meta   <= midi_in;
      rx_s      <= rx_meta;
      rx_s_prev <= rx_s;
    end
  end

  // Receive FSM with bit timing and registered byte/error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      baud_cnt         <= '0;
      bit_idx          <= '0;
      shift_reg        <= '0;
      new_byte_q       <= '0;
      new_byte_ready_q <= 1'b0;
      framing_error_q  <= 1'b0;
    end else begin
      new_byte_ready_q <= 1'b0;
      framing_error_q  <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (start_edge) state <= START;
        end
        START: begin
          if (tc) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (tc) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (tc) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              // Real-time bytes are swallowed here so message capture never sees them.
              if (!(FILTER_REALTIME && (shift_reg >= 8'hF8))) begin
                new_byte_q       <= shift_reg;
                new_byte_ready_q <= 1'b1;
              end
            end else begin
              framing_error_q <= 1'b1;
              state           <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        BREAK: begin
          baud_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign rx_bus.new_byte_ready = new_byte_ready_q;
  assign rx_bus.new_byte       = new_byte_q;
  assign rx_bus.framing_error  = framing_error_q;
  assign rx_bus.busy           = (state != IDLE);

endmodule
